interrupt_scheduler: RTL and testbench

//  Machine-level interrupt source block and arbiter that feeds the trap handler FSM.

---
 rtl/interrupt_scheduler.sv | 156 +++++++++++++++
 tb/tb_interrupt_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_scheduler.sv
// Machine-level interrupt sources (mtime/mtimecmp, msip, synchronised external IRQ) and a
// fixed-priority arbiter that hands one interrupt at a time to the trap handler FSM.
module interrupt_scheduler #(
    parameter int TW       = 32,
    parameter int PRESCALE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ext_irq,
    input  logic          mstatus_mie,
    input  logic          mie_meie,
    input  logic          mie_msie,
    input  logic          mie_mtie,
    input  logic          exception_raised,
    input  logic          trap_idle,
    input  logic          mret,
    input  logic          msip_set,
    input  logic          msip_clr,
    input  logic          mtime_we,
    input  logic          mtimecmp_we,
    input  logic [TW-1:0] wdata,
    output logic [TW-1:0] mtime,
    output logic [31:0]   mip,
    output logic          interruptRaised,
    output logic          machineExternalInterrupt,
    output logic          machineSoftwareInterrupt,
    output logic          machineTimerInterrupt
);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_TRAP, IN_HANDLER} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] mtime_q, mtime_d;
    logic [TW-1:0] mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic          sync1_q, sync2_q;
    logic [2:0]    cause_q, cause_d;
    logic          busy_seen_q, busy_seen_d;
    logic          mret_seen_q, mret_seen_d;

    logic          meip, mtip;
    logic [2:0]    eligible;
    logic [2:0]    winner;

    always_comb begin
        presc_d    = presc_q;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (mtime_we) begin
            mtime_d = wdata;
            presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            mtime_d = mtime_q + TW'(1);
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
        if (mtimecmp_we) begin
            mtimecmp_d = wdata;
        end
        if (msip_clr) begin
            msip_d = 1'b0;
        end else if (msip_set) begin
            msip_d = 1'b1;
        end
    end

    always_comb begin
        meip     = sync2_q;
        mtip     = (mtime_q >= mtimecmp_q);
        mip      = 32'd0;
        mip[11]  = meip;
        mip[7]   = mtip;
        mip[3]   = msip_q;
        // Bit order {external, software, timer} doubles as the priority order.
        eligible = {meip & mie_meie, msip_q & mie_msie, mtip & mie_mtie} & {3{mstatus_mie}};
        if (eligible[2]) begin
            winner = 3'b100;
        end else if (eligible[1]) begin
            winner = 3'b010;
        end else begin
            winner = 3'b001;
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        busy_seen_d = busy_seen_q;
        mret_seen_d = mret_seen_q;
        case (state_q)
            IDLE: begin
                if ((|eligible) && trap_idle && !exception_raised) begin
                    state_d = ISSUE;
                    cause_d = winner;
                end
            end
            ISSUE: begin
                state_d     = WAIT_TRAP;
                busy_seen_d = 1'b0;
                mret_seen_d = 1'b0;
            end
            WAIT_TRAP: begin
                // Trap entry is done once the handler FSM has left idle and come back.
                if (busy_seen_q && trap_idle) begin
                    state_d = (mret_seen_q || mret) ? IDLE : IN_HANDLER;
                end else begin
                    if (!trap_idle) busy_seen_d = 1'b1;
                    if (mret)       mret_seen_d = 1'b1;
                end
            end
            IN_HANDLER: begin
                if (mret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cause_q     <= '0;
            busy_seen_q <= 1'b0;
            mret_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            sync1_q     <= ext_irq;
            sync2_q     <= sync1_q;
            cause_q     <= cause_d;
            busy_seen_q <= busy_seen_d;
            mret_seen_q <= mret_seen_d;
        end
    end

    assign mtime                    = mtime_q;
    assign interruptRaised          = (state_q == ISSUE);
    assign machineExternalInterrupt = interruptRaised & cause_q[2];
    assign machineSoftwareInterrupt = interruptRaised & cause_q[1];
    assign machineTimerInterrupt    = interruptRaised & cause_q[0];

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Bench for interrupt_scheduler: directed scenarios plus a randomized run against a
// behavioural model of the timer, pending sources and request handshake.
module tb_interrupt_scheduler;

    logic        clk = 1'b0;
    logic        rst, ext_irq, mstatus_mie, mie_meie, mie_msie, mie_mtie;
    logic        exception_raised, trap_idle, mret, msip_set, msip_clr, mtime_we, mtimecmp_we;
    logic [31:0] wdata;
    logic [31:0] mtime, mip, mtime4, mip4;
    logic        irq, ext, sw, tmr, irq4, ext4, sw4, tmr4;
    logic [3:0]  outs;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: timer/pending registers and the request lifecycle.
    logic [31:0] m_mtime, m_cmp;
    bit          m_msip, m_s1, m_s2;
    bit          m_pulse, m_busy, m_entered, m_saw_busy, m_early_mret;
    int          m_cause;

    always #5 clk = ~clk;
    assign outs = {irq, ext, sw, tmr};

    interrupt_scheduler #(.TW(32), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .ext_irq(ext_irq), .mstatus_mie(mstatus_mie),
        .mie_meie(mie_meie), .mie_msie(mie_msie), .mie_mtie(mie_mtie),
        .exception_raised(exception_raised), .trap_idle(trap_idle), .mret(mret),
        .msip_set(msip_set), .msip_clr(msip_clr), .mtime_we(mtime_we),
        .mtimecmp_we(mtimecmp_we), .wdata(wdata), .mtime(mtime), .mip(mip),
        .interruptRaised(irq), .machineExternalInterrupt(ext),
        .machineSoftwareInterrupt(sw), .machineTimerInterrupt(tmr)
    );

    interrupt_scheduler #(.TW(32), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .ext_irq(ext_irq), .mstatus_mie(mstatus_mie),
        .mie_meie(mie_meie), .mie_msie(mie_msie), .mie_mtie(mie_mtie),
        .exception_raised(exception_raised), .trap_idle(trap_idle), .mret(mret),
        .msip_set(msip_set), .msip_clr(msip_clr), .mtime_we(mtime_we),
        .mtimecmp_we(mtimecmp_we), .wdata(wdata), .mtime(mtime4), .mip(mip4),
        .interruptRaised(irq4), .machineExternalInterrupt(ext4),
        .machineSoftwareInterrupt(sw4), .machineTimerInterrupt(tmr4)
    );

    function automatic void model_edge();
        bit pe, ps, pt, ee, es, et;
        if (rst) begin
            m_mtime = 32'd0; m_cmp = 32'hFFFF_FFFF; m_msip = 0; m_s1 = 0; m_s2 = 0;
            m_pulse = 0; m_busy = 0; m_entered = 0; m_saw_busy = 0; m_early_mret = 0;
            m_cause = 0;
            return;
        end
        pe = m_s2; ps = m_msip; pt = (m_mtime >= m_cmp);
        ee = pe && mie_meie && mstatus_mie;
        es = ps && mie_msie && mstatus_mie;
        et = pt && mie_mtie && mstatus_mie;
        if (m_pulse) begin
            m_pulse = 0; m_saw_busy = 0; m_early_mret = 0; m_entered = 0;
        end else if (m_busy) begin
            if (!m_entered) begin
                if (m_saw_busy && trap_idle) begin
                    if (m_early_mret || mret) m_busy = 0;
                    else m_entered = 1;
                end else begin
                    if (!trap_idle) m_saw_busy = 1;
                    if (mret) m_early_mret = 1;
                end
            end else if (mret) begin
                m_busy = 0; m_entered = 0;
            end
        end else if ((ee || es || et) && trap_idle && !exception_raised) begin
            m_pulse = 1; m_busy = 1;
            m_cause = ee ? 1 : (es ? 2 : 3);
        end
        m_s2 = m_s1; m_s1 = ext_irq;
        if (msip_clr) m_msip = 0; else if (msip_set) m_msip = 1;
        if (mtime_we) m_mtime = wdata; else m_mtime = m_mtime + 32'd1;
        if (mtimecmp_we) m_cmp = wdata;
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_trap();
        trap_idle = 1'b0; step();
        trap_idle = 1'b1; step();
        mret = 1'b1; step();
        mret = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step();
        n_tests++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL reset_outs: got %b want 0000", outs); end
        n_tests++; if (mtime !== 32'd0) begin n_fail++; $display("FAIL reset_mtime: got %h want 0", mtime); end
        n_tests++; if (mip !== 32'd0) begin n_fail++; $display("FAIL reset_mip: got %h want 0", mip); end
        rst = 1'b0;
    endtask

    task automatic test_timer();
        bit found = 0;
        mstatus_mie = 1; mie_mtie = 1; mie_msie = 0; mie_meie = 0; trap_idle = 1;
        mtime_we = 1; wdata = 32'd0; step(); mtime_we = 0;
        mtimecmp_we = 1; wdata = 32'd5; step(); mtimecmp_we = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mip[7]) found = 1; else step();
        end
        n_tests++; if (!found || mtime !== 32'd5) begin n_fail++; $display("FAIL timer_mtip_at_cmp: mtime %0d found %0d want 5", mtime, found); end
        n_tests++; if (mip !== 32'h080 || irq !== 1'b0) begin n_fail++; $display("FAIL timer_mip: mip %h irq %b want 080 0", mip, irq); end
        step();
        n_tests++; if (outs !== 4'b1001) begin n_fail++; $display("FAIL timer_pulse: got %b want 1001", outs); end
        mtimecmp_we = 1; wdata = 32'hFFFF_FFFF; step(); mtimecmp_we = 0;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL timer_single_cycle: got %b want 0", irq); end
        finish_trap(); step();
        n_tests++; if (irq !== 1'b0 || mip[7] !== 1'b0) begin n_fail++; $display("FAIL timer_cleared: irq %b mtip %b want 0 0", irq, mip[7]); end
        mie_mtie = 0;
    endtask

    task automatic test_priority();
        mstatus_mie = 0; mie_meie = 1; mie_msie = 1; mie_mtie = 1;
        ext_irq = 1; msip_set = 1; step(); msip_set = 0; step(); step();
        n_tests++; if (mip !== 32'h808 || irq !== 1'b0) begin n_fail++; $display("FAIL prio_pending: mip %h irq %b want 808 0", mip, irq); end
        mstatus_mie = 1; step();
        n_tests++; if (outs !== 4'b1100) begin n_fail++; $display("FAIL prio_external_first: got %b want 1100", outs); end
        ext_irq = 0; step();
        finish_trap();
        n_tests++; if (irq !== 1'b0 || mip !== 32'h008) begin n_fail++; $display("FAIL prio_after_mret: irq %b mip %h want 0 008", irq, mip); end
        step();
        n_tests++; if (outs !== 4'b1010) begin n_fail++; $display("FAIL prio_software_second: got %b want 1010", outs); end
        msip_clr = 1; step(); msip_clr = 0;
        finish_trap(); step();
        n_tests++; if (irq !== 1'b0 || mip !== 32'd0) begin n_fail++; $display("FAIL prio_drained: irq %b mip %h want 0 0", irq, mip); end
    endtask

    task automatic test_gating();
        bit seen = 0;
        mstatus_mie = 0; mie_meie = 0; mie_mtie = 0; mie_msie = 1;
        msip_set = 1; step(); msip_set = 0;
        n_tests++; if (mip !== 32'h008) begin n_fail++; $display("FAIL gate_mip: got %h want 008", mip); end
        for (int i = 0; i < 3; i++) begin step(); seen |= irq; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL gate_no_request: got %b want 0", seen); end
        mstatus_mie = 1; step();
        n_tests++; if (outs !== 4'b1010) begin n_fail++; $display("FAIL gate_enable_request: got %b want 1010", outs); end
        msip_clr = 1; step(); msip_clr = 0;
        finish_trap();
    endtask

    task automatic test_blocking();
        bit seen = 0;
        mstatus_mie = 1; mie_msie = 1; exception_raised = 1;
        msip_set = 1; step(); msip_set = 0;
        for (int i = 0; i < 4; i++) begin step(); seen |= irq; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL block_exception: got %b want 0", seen); end
        exception_raised = 0; trap_idle = 0;
        for (int i = 0; i < 4; i++) begin step(); seen |= irq; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL block_trap_busy: got %b want 0", seen); end
        trap_idle = 1; step();
        n_tests++; if (outs !== 4'b1010) begin n_fail++; $display("FAIL block_release: got %b want 1010", outs); end
        msip_clr = 1; step(); msip_clr = 0;
        finish_trap();
    endtask

    task automatic test_prescale_wrap();
        mstatus_mie = 0;
        mtime_we = 1; wdata = 32'hFFFF_FFFF; step(); mtime_we = 0;
        n_tests++; if (mtime4 !== 32'hFFFF_FFFF || mtime !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_load: mtime4 %h mtime %h want ffffffff", mtime4, mtime); end
        step();
        n_tests++; if (mtime !== 32'd0) begin n_fail++; $display("FAIL wrap_p1: got %h want 0", mtime); end
        step(); step();
        n_tests++; if (mtime4 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_p4_hold: got %h want ffffffff", mtime4); end
        step();
        n_tests++; if (mtime4 !== 32'd0) begin n_fail++; $display("FAIL wrap_p4: got %h want 0", mtime4); end
        msip_set = 1; msip_clr = 1; step(); msip_set = 0; msip_clr = 0;
        n_tests++; if (mip[3] !== 1'b0) begin n_fail++; $display("FAIL msip_clr_wins: got %b want 0", mip[3]); end
    endtask

    task automatic test_reset_midflight();
        mstatus_mie = 1; mie_msie = 1;
        msip_set = 1; step(); msip_set = 0; step();
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_issue: got %b want 1", irq); end
        step();
        rst = 1; step();
        n_tests++; if (outs !== 4'b0000 || mtime !== 32'd0 || mip !== 32'd0) begin n_fail++; $display("FAIL mid_reset: outs %b mtime %h mip %h want 0", outs, mtime, mip); end
        rst = 0;
        msip_set = 1; step(); msip_set = 0;
        n_tests++; if (irq !== 1'b0 || mip !== 32'h008) begin n_fail++; $display("FAIL mid_rearm: irq %b mip %h want 0 008", irq, mip); end
        step();
        n_tests++; if (outs !== 4'b1010) begin n_fail++; $display("FAIL mid_reissue: got %b want 1010", outs); end
        msip_clr = 1; step(); msip_clr = 0;
        finish_trap();
    endtask

    task automatic test_random();
        logic [31:0] exp_mip;
        logic [3:0]  exp_outs;
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 1500; i++) begin
            rst              = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) ext_irq = ~ext_irq;
            mstatus_mie      = ($urandom_range(0, 9) != 0);
            mie_meie         = ($urandom_range(0, 4) != 0);
            mie_msie         = ($urandom_range(0, 4) != 0);
            mie_mtie         = ($urandom_range(0, 4) != 0);
            exception_raised = ($urandom_range(0, 9) == 0);
            trap_idle        = ($urandom_range(0, 4) != 0);
            mret             = ($urandom_range(0, 7) == 0);
            msip_set         = ($urandom_range(0, 9) == 0);
            msip_clr         = ($urandom_range(0, 9) == 0);
            mtime_we         = ($urandom_range(0, 49) == 0);
            mtimecmp_we      = ($urandom_range(0, 29) == 0);
            wdata            = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                                           : $urandom_range(0, 64);
            step();
            exp_mip  = (32'(m_s2) << 11) | (32'(m_mtime >= m_cmp) << 7) | (32'(m_msip) << 3);
            exp_outs = {m_pulse, m_pulse && m_cause == 1, m_pulse && m_cause == 2, m_pulse && m_cause == 3};
            n_tests++;
            if (mtime !== m_mtime || mip !== exp_mip || outs !== exp_outs) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: mtime %h mip %h outs %b want %h %h %b",
                         i, mtime, mip, outs, m_mtime, exp_mip, exp_outs);
            end
        end
        rst = 0; mret = 0; msip_set = 0; msip_clr = 0; mtime_we = 0; mtimecmp_we = 0;
    endtask

    initial begin
        rst = 1; ext_irq = 0; mstatus_mie = 0; mie_meie = 0; mie_msie = 0; mie_mtie = 0;
        exception_raised = 0; trap_idle = 1; mret = 0; msip_set = 0; msip_clr = 0;
        mtime_we = 0; mtimecmp_we = 0; wdata = 32'd0;
        test_reset();
        test_timer();
        test_priority();
        test_gating();
        test_blocking();
        test_prescale_wrap();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
